// File: rtl/mimc_pkg.sv
// mimc_pkg: shared definitions for the MiMC Feistel engine.
//   - BN254 scalar-field modulus and default width/round count
//   - engine FSM state encoding
//   - pow_mult_count(): modular multiplies per S-box exponent (0 = illegal)
package mimc_pkg;

  localparam int unsigned BN254_N_BITS     = 254;
  localparam int unsigned DEFAULT_N_ROUNDS = 220;
  localparam logic [BN254_N_BITS-1:0] BN254_PRIME =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    POW  = 2'd2,
    DONE = 2'd3
  } mimc_state_e;

  function automatic int unsigned pow_mult_count(input int unsigned exponent);
    case (exponent)
      3:       return 2;
      5:       return 3;
      7:       return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/galois_mult.sv
// galois_mult: bit-serial modular multiplier, result = a * b mod PRIME.
// MSB-first double-and-add, one bit of b per cycle (N_BITS cycles per product).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous abort of any product in flight
//   start           latch a, b and begin (ignored while busy only by caller contract)
//   a, b            operands, both < PRIME
//   done            one-cycle pulse, result valid in that cycle and held afterwards
//   result          product
module galois_mult
  import mimc_pkg::*;
#(
  parameter int unsigned             N_BITS = BN254_N_BITS,
  parameter logic [N_BITS-1:0]       PRIME  = N_BITS'(BN254_PRIME)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int unsigned CNT_W = $clog2(N_BITS + 1);

  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [N_BITS-1:0] dbl;
  logic [N_BITS-1:0] nxt;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  // Operands are already reduced, so one conditional subtract suffices.
  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] x,
                                                input logic [N_BITS-1:0] y);
    logic [N_BITS:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, PRIME}) sum = sum - {1'b0, PRIME};
    return sum[N_BITS-1:0];
  endfunction

  always_comb begin
    dbl = mod_add(acc, acc);
    nxt = b_q[N_BITS-1] ? mod_add(dbl, a_q) : dbl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q  <= a;
        b_q  <= b;
        acc  <= '0;
        cnt  <= CNT_W'(N_BITS);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= nxt;
        b_q <= b_q << 1;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/mimc_pow_unit.sv
// mimc_pow_unit: S-box x^EXPONENT mod PRIME over a single galois_mult.
// Chains: e=3: x2, x3   e=5: x2, x4, x5   e=7: x2, x4, x6, x7
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        abandon the current chain
//   start        latch base and begin
//   base         x, < PRIME
//   done         one-cycle pulse when result is valid
//   result       x^EXPONENT mod PRIME
module mimc_pow_unit
  import mimc_pkg::*;
#(
  parameter int unsigned       N_BITS   = BN254_N_BITS,
  parameter logic [N_BITS-1:0] PRIME    = N_BITS'(BN254_PRIME),
  parameter int unsigned       EXPONENT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [N_BITS-1:0] base,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int unsigned N_MUL = pow_mult_count(EXPONENT);

  generate
    if (N_MUL == 0) begin : g_bad_exponent
      $error("mimc_pow_unit: EXPONENT must be 3, 5 or 7");
    end
  endgenerate

  localparam logic [1:0] LAST_STEP = 2'(N_MUL - 1);

  logic [N_BITS-1:0] x;
  logic [N_BITS-1:0] x2;
  logic [N_BITS-1:0] cur;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic [N_BITS-1:0] product;
  logic [1:0]        step;
  logic              mul_start;
  logic              mul_done;
  logic              busy;

  // Step 0 squares x, the last step folds in x once more; in between the
  // running product is squared (x4) or multiplied by x2 (x6 for e=7).
  always_comb begin
    op_a = cur;
    op_b = x;
    if (step == 2'd0) begin
      op_a = x;
      op_b = x;
    end else if (step == LAST_STEP) begin
      op_b = x;
    end else if (step == 2'd1) begin
      op_b = cur;
    end else begin
      op_b = x2;
    end
  end

  galois_mult #(
    .N_BITS (N_BITS),
    .PRIME  (PRIME)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .start  (mul_start),
    .a      (op_a),
    .b      (op_b),
    .done   (mul_done),
    .result (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      x2        <= '0;
      cur       <= '0;
      step      <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      step      <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        x         <= base;
        step      <= '0;
        mul_start <= 1'b1;
        busy      <= 1'b1;
      end else if (busy && mul_done) begin
        cur <= product;
        if (step == 2'd0) x2 <= product;
        if (step == LAST_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          step      <= step + 2'd1;
          mul_start <= 1'b1;
        end
      end
    end
  end

  assign result = cur;

endmodule

// File: rtl/mimc_feistel_engine.sv
// mimc_feistel_engine: iterative MiMC Feistel permutation/cipher core.
// Runs N_ROUNDS rounds on one (left, right) block:
//   t = left + rc[i] + key, s = t^EXPONENT + right, swap except on the last round.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   abort                  (only with MIMC_ENGINE_ABORT_EN) drop the block in flight
//   in_valid/in_ready      input block handshake (ready only when idle)
//   in_left/in_right       block halves, < PRIME
//   in_key, in_cipher_mode key, and whether to use it (0 = permutation, key = 0)
//   rc_index/rc_value      round-constant ROM lookup, rc_value combinational
//   out_valid/out_ready    result handshake, outputs held under backpressure
//   out_left/out_right     result halves
// Build option: define MIMC_ENGINE_ABORT_EN to add the abort input.
module mimc_feistel_engine
  import mimc_pkg::*;
#(
  parameter int unsigned       N_BITS   = BN254_N_BITS,
  parameter logic [N_BITS-1:0] PRIME    = N_BITS'(BN254_PRIME),
  parameter int unsigned       N_ROUNDS = DEFAULT_N_ROUNDS,
  parameter int unsigned       EXPONENT = 5,
  parameter int unsigned       IDX_W    = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MIMC_ENGINE_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_left,
  input  logic [N_BITS-1:0] in_right,
  input  logic [N_BITS-1:0] in_key,
  input  logic              in_cipher_mode,
  output logic [IDX_W-1:0]  rc_index,
  input  logic [N_BITS-1:0] rc_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_left,
  output logic [N_BITS-1:0] out_right
);

  generate
    if (N_ROUNDS < 1) begin : g_bad_rounds
      $error("mimc_feistel_engine: N_ROUNDS must be >= 1");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(N_ROUNDS - 1);

  mimc_state_e       state;
  logic [N_BITS-1:0] left;
  logic [N_BITS-1:0] right;
  logic [N_BITS-1:0] key;
  logic [IDX_W-1:0]  round;
  logic [N_BITS-1:0] t;
  logic [N_BITS-1:0] s;
  logic [N_BITS-1:0] pow_result;
  logic              pow_start;
  logic              pow_done;
  logic              abort_hit;

`ifdef MIMC_ENGINE_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] x,
                                                input logic [N_BITS-1:0] y);
    logic [N_BITS:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, PRIME}) sum = sum - {1'b0, PRIME};
    return sum[N_BITS-1:0];
  endfunction

  // rc_value is only meaningful in LOAD; the pow unit latches t on that edge.
  assign t         = mod_add(mod_add(left, rc_value), key);
  assign s         = mod_add(pow_result, right);
  assign pow_start = (state == LOAD) && !abort_hit;
  assign rc_index  = round;

  mimc_pow_unit #(
    .N_BITS   (N_BITS),
    .PRIME    (PRIME),
    .EXPONENT (EXPONENT)
  ) u_pow (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (abort_hit),
    .start  (pow_start),
    .base   (t),
    .done   (pow_done),
    .result (pow_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      left      <= '0;
      right     <= '0;
      key       <= '0;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
    end else if (abort_hit) begin
      state     <= IDLE;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            left     <= in_left;
            right    <= in_right;
            key      <= in_cipher_mode ? in_key : '0;
            round    <= '0;
            in_ready <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: state <= POW;
        POW: begin
          if (pow_done) begin
            if (round == LAST_ROUND) begin
              out_left  <= left;
              out_right <= s;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              left  <= s;
              right <= left;
              round <= round + IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimc_feistel_engine.sv
// Bench for mimc_feistel_engine over the 8-bit field GF(251).
// Four engines share the data inputs: (rounds, exponent) = (2,3), (1,3), (4,5), (3,7).
// Round-constant ROM: rc = {1, 2, 7, 200}.
module tb_mimc_feistel_engine;

  localparam int unsigned P    = 251;
  localparam int          NDUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       in_valid [NDUT];
  logic       in_ready [NDUT];
  logic [7:0] in_left, in_right, in_key;
  logic       in_cipher_mode;
  logic       out_ready;
  logic [7:0] rc_value [NDUT];
  logic       out_valid [NDUT];
  logic [7:0] out_left [NDUT];
  logic [7:0] out_right [NDUT];
  logic [0:0] idx0, idx1;
  logic [1:0] idx2, idx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rc_of(input int unsigned i);
    case (i)
      0:       return 8'd1;
      1:       return 8'd2;
      2:       return 8'd7;
      default: return 8'd200;
    endcase
  endfunction

  function automatic int unsigned rounds_of(input int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned exp_of(input int d);
    case (d)
      2: return 5;
      3: return 7;
      default: return 3;
    endcase
  endfunction

  assign rc_value[0] = rc_of(32'(idx0));
  assign rc_value[1] = rc_of(32'(idx1));
  assign rc_value[2] = rc_of(32'(idx2));
  assign rc_value[3] = rc_of(32'(idx3));

  mimc_feistel_engine #(.N_BITS(8), .PRIME(8'd251), .N_ROUNDS(2), .EXPONENT(3)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MIMC_ENGINE_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_left(in_left), .in_right(in_right),
    .in_key(in_key), .in_cipher_mode(in_cipher_mode), .rc_index(idx0), .rc_value(rc_value[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_left(out_left[0]), .out_right(out_right[0]));

  mimc_feistel_engine #(.N_BITS(8), .PRIME(8'd251), .N_ROUNDS(1), .EXPONENT(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MIMC_ENGINE_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_left(in_left), .in_right(in_right),
    .in_key(in_key), .in_cipher_mode(in_cipher_mode), .rc_index(idx1), .rc_value(rc_value[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_left(out_left[1]), .out_right(out_right[1]));

  mimc_feistel_engine #(.N_BITS(8), .PRIME(8'd251), .N_ROUNDS(4), .EXPONENT(5)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef MIMC_ENGINE_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_left(in_left), .in_right(in_right),
    .in_key(in_key), .in_cipher_mode(in_cipher_mode), .rc_index(idx2), .rc_value(rc_value[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_left(out_left[2]), .out_right(out_right[2]));

  mimc_feistel_engine #(.N_BITS(8), .PRIME(8'd251), .N_ROUNDS(3), .EXPONENT(7)) dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef MIMC_ENGINE_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_left(in_left), .in_right(in_right),
    .in_key(in_key), .in_cipher_mode(in_cipher_mode), .rc_index(idx3), .rc_value(rc_value[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready), .out_left(out_left[3]), .out_right(out_right[3]));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic over the Feistel rounds.
  function automatic int unsigned powmod(input int unsigned x, input int unsigned e);
    int unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * x) % P;
    return r;
  endfunction

  task automatic ref_block(input int d, input int unsigned l, input int unsigned r,
                           input int unsigned k, input bit mode,
                           output int unsigned ol, output int unsigned orr);
    int unsigned kk, tt, ss, n;
    kk = mode ? k : 0;
    n  = rounds_of(d);
    ol = 0;
    orr = 0;
    for (int unsigned i = 0; i < n; i++) begin
      tt = (l + rc_of(i) + kk) % P;
      ss = (powmod(tt, exp_of(d)) + r) % P;
      if (i == n - 1) begin
        ol  = l;
        orr = ss;
      end else begin
        r = l;
        l = ss;
      end
    end
  endtask

  task automatic start_block(input int d, input int unsigned l, input int unsigned r,
                             input int unsigned k, input bit mode);
    @(negedge clk);
    check("ready_before_accept", in_ready[d], 1);
    in_left = 8'(l); in_right = 8'(r); in_key = 8'(k); in_cipher_mode = mode;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    check("busy_after_accept", in_ready[d], 0);
  endtask

  task automatic wait_result(input int d);
    int n = 0;
    while (!out_valid[d] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("result_timeout", out_valid[d], 1);
  endtask

  // Runs one block with out_ready high, checks against constants or model.
  task automatic run_block(input string tag, input int d, input int unsigned l,
                           input int unsigned r, input int unsigned k, input bit mode,
                           input int unsigned exp_l, input int unsigned exp_r);
    start_block(d, l, r, k, mode);
    wait_result(d);
    check({tag, "_left"}, out_left[d], exp_l);
    check({tag, "_right"}, out_right[d], exp_r);
    @(negedge clk);
    check({tag, "_single_pulse"}, out_valid[d], 0);
    check({tag, "_idle_again"}, in_ready[d], 1);
  endtask

  initial begin
    int unsigned el, er, l, r, k;
    int d;
    bit m;
    rst_n = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_left = '0; in_right = '0; in_key = '0; in_cipher_mode = 1'b0;
    for (int i = 0; i < NDUT; i++) in_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("rst_in_ready", in_ready[i], 1);
      check("rst_out_valid", out_valid[i], 0);
      check("rst_out_left", out_left[i], 0);
      check("rst_out_right", out_right[i], 0);
    end
    check("rst_rc_index", idx2, 0);
    rst_n = 1'b1;

    // Directed vectors.
    run_block("two_rounds", 0, 2, 3, 0, 1'b1, 30, 140);
    run_block("one_round_key", 1, 2, 3, 5, 1'b1, 2, 13);
    run_block("perm_mode", 1, 2, 3, 5, 1'b0, 2, 30);
    run_block("wrap", 1, 250, 3, 0, 1'b1, 250, 3);

    // Backpressure: result held, second block ignored.
    out_ready = 1'b0;
    start_block(0, 2, 3, 0, 1'b1);
    wait_result(0);
    for (int i = 0; i < 10; i++) begin
      in_left = 8'd9; in_right = 8'd9; in_valid[0] = 1'b1;
      @(negedge clk);
      check("bp_valid", out_valid[0], 1);
      check("bp_left", out_left[0], 30);
      check("bp_right", out_right[0], 140);
      check("bp_in_ready", in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid[0], 0);
    check("bp_release_ready", in_ready[0], 1);
    repeat (5) @(negedge clk);
    check("bp_second_ignored", in_ready[0], 1);

    // Reset in the middle of a block.
    start_block(0, 17, 99, 0, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_in_ready", in_ready[0], 1);
    check("midrst_rc_index", idx0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_block(0, 40, 77, 11, 1'b1, el, er);
    run_block("after_rst", 0, 40, 77, 11, 1'b1, el, er);

`ifdef MIMC_ENGINE_ABORT_EN
    begin
      int n = 0;
      int pulses = 0;
      start_block(0, 5, 6, 7, 1'b1);
      while (idx0 != 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_round1", idx0, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_in_ready", in_ready[0], 1);
      check("abort_out_valid", out_valid[0], 0);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (out_valid[0]) pulses++;
      end
      check("abort_no_result", pulses, 0);
      ref_block(0, 5, 6, 7, 1'b1, el, er);
      run_block("after_abort", 0, 5, 6, 7, 1'b1, el, er);
    end
`endif

    // Randomised blocks across all four engine configurations.
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, NDUT - 1));
      l = $urandom_range(0, P - 1);
      r = $urandom_range(0, P - 1);
      k = $urandom_range(0, P - 1);
      m = 1'($urandom_range(0, 1));
      ref_block(d, l, r, k, m, el, er);
      run_block("rand", d, l, r, k, m, el, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
